// File: rtl/keyed_seq_fsm.sv
// rtl/keyed_seq_fsm.sv - key-locked sequencing FSM with decoy twin states
// Each state is a functional index plus a genuine/decoy mode; illegal codes recover to S0.
module keyed_seq_fsm #(
   parameter int               NUM_ST      = 8,
   parameter int               KEY_W       = 4,
   parameter logic [KEY_W-1:0] CORRECT_KEY = 4'b1010,
   parameter int               OUT_W       = 16,
   parameter int               LOCK_THRESH = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             adv,
   input  logic             restart,
   input  logic [KEY_W-1:0] keyinput,
   output logic [OUT_W-1:0] y
);

   localparam int IW = (NUM_ST > 1) ? $clog2(NUM_ST) : 1;
   localparam int CW = (LOCK_THRESH > 0) ? $clog2(LOCK_THRESH + 1) : 1;

   // one-hot-ish mode code so that 2'b00 and 2'b11 are detectably illegal
   typedef enum logic [1:0] {
      MODE_S = 2'b01,
      MODE_D = 2'b10
   } mode_t;

   mode_t           mode, mode_nxt;
   logic [IW-1:0]   idx, idx_nxt;
   logic [CW-1:0]   mis_cnt, mis_nxt;
   logic [OUT_W-1:0] y_nxt;

   function automatic logic [OUT_W-1:0] pat(input int i);
      logic [OUT_W-1:0] p;
      p = '0;
      for (int b = 0; b < OUT_W; b++) begin
         p[b] = (b == (i % OUT_W)) || (b == ((i + NUM_ST) % OUT_W));
      end
      return p;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst) begin
         mode    <= MODE_S;
         idx     <= '0;
         mis_cnt <= '0;
         y       <= '0;
      end else begin
         mode    <= mode_nxt;
         idx     <= idx_nxt;
         mis_cnt <= mis_nxt;
         y       <= y_nxt;
      end
   end

   always_comb begin
      int   cur;
      int   tgt;
      logic hold;
      logic legal;
      logic key_bad;

      mode_nxt = MODE_S;
      idx_nxt  = '0;
      mis_nxt  = mis_cnt;
      y_nxt    = y;
      cur      = int'(idx);
      tgt      = 0;
      hold     = 1'b0;
      key_bad  = 1'b0;

      legal = ((mode == MODE_S) && (cur < NUM_ST)) ||
              ((mode == MODE_D) && (cur >= 1) && (cur <= KEY_W));

      if (!legal) begin
         y_nxt = pat(0);
      end else begin
         if (restart)  tgt = 0;
         else if (adv) tgt = (cur + 1) % NUM_ST;
         else          hold = 1'b1;

         // constant-index key compare keeps the selects at natural width
         for (int k = 1; k <= KEY_W; k++) begin
            if (tgt == k) key_bad = (keyinput[k-1] != CORRECT_KEY[k-1]);
         end

         if (hold) begin
            mode_nxt = mode;
            idx_nxt  = idx;
            if (mode == MODE_S) y_nxt = pat(cur);
         end else if (key_bad) begin
            mode_nxt = MODE_D;
            idx_nxt  = IW'(tgt);
            if (int'(mis_cnt) < LOCK_THRESH) mis_nxt = mis_cnt + CW'(1);
            y_nxt = (int'(mis_nxt) < LOCK_THRESH) ? pat(tgt) : ~pat(tgt);
         end else begin
            mode_nxt = MODE_S;
            idx_nxt  = IW'(tgt);
            y_nxt    = pat(tgt);
         end
      end
   end

endmodule
